// File: rtl/fft_sequencer_if.sv
// Control bundle between the FFT sequencer and the input/output streams,
// sample RAM, butterfly pipeline and twiddle ROM.
interface fft_sequencer_if #(
    parameter int STAGES = 4
);
    localparam int SW = (STAGES > 1) ? $clog2(STAGES) : 1;

    logic              i_start;
    logic              i_in_valid;
    logic              o_in_ready;
    logic              o_load_we;
    logic [STAGES-1:0] o_load_addr;
    logic              o_rd_en;
    logic [STAGES-1:0] o_rd_addr_a;
    logic [STAGES-1:0] o_rd_addr_b;
    logic [STAGES-2:0] o_tw_idx;
    logic              o_wb_en;
    logic [STAGES-1:0] o_wb_addr_a;
    logic [STAGES-1:0] o_wb_addr_b;
    logic              o_out_rd_en;
    logic [STAGES-1:0] o_out_addr;
    logic              o_out_valid;
    logic [SW-1:0]     o_stage;
    logic              o_busy;
    logic              o_done;

    modport master (
        input  i_start, i_in_valid,
        output o_in_ready, o_load_we, o_load_addr,
        output o_rd_en, o_rd_addr_a, o_rd_addr_b, o_tw_idx,
        output o_wb_en, o_wb_addr_a, o_wb_addr_b,
        output o_out_rd_en, o_out_addr, o_out_valid,
        output o_stage, o_busy, o_done
    );

    modport slave (
        output i_start, i_in_valid,
        input  o_in_ready, o_load_we, o_load_addr,
        input  o_rd_en, o_rd_addr_a, o_rd_addr_b, o_tw_idx,
        input  o_wb_en, o_wb_addr_a, o_wb_addr_b,
        input  o_out_rd_en, o_out_addr, o_out_valid,
        input  o_stage, o_busy, o_done
    );
endinterface

// File: rtl/fft_sequencer.sv
// In-place radix-2 DIT FFT sequencer: bit-reversed load, STAGES x (N/2 + BF_LAT) compute, natural-order unload.
// Input is stalled by i_in_valid gaps during LOAD only; compute and unload run free once started.
module fft_sequencer #(
    parameter int STAGES = 4,
    parameter int BF_LAT = 2
) (
    input  logic            i_clk,
    input  logic            i_rst,
    fft_sequencer_if.master bus
);
    localparam int KW = STAGES - 1;
    localparam int SW = (STAGES > 1) ? $clog2(STAGES) : 1;
    localparam int DW = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_COMPUTE,
        S_DRAIN,
        S_UNLOAD,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [STAGES-1:0] cnt;
    logic [KW-1:0]     bf_k;
    logic [SW-1:0]     stage;
    logic [DW-1:0]     drain_cnt;

    logic              load_acc;
    logic              last_cnt;
    logic              last_bf;
    logic              last_stage;
    logic              last_drain;
    logic              rd_en;
    logic [STAGES-1:0] load_rev;
    logic [STAGES-1:0] k_ext;
    logic [STAGES-1:0] lo_mask;
    logic [STAGES-1:0] lo_bits;
    logic [STAGES-1:0] addr_a;
    logic [STAGES-1:0] addr_b;
    logic [STAGES-1:0] tw_full;
    logic [SW-1:0]     tw_shift;
    logic [STAGES-1:0] rd_a;
    logic [STAGES-1:0] rd_b;

    logic [BF_LAT-1:0] wb_vld;
    logic [STAGES-1:0] wb_pa [BF_LAT];
    logic [STAGES-1:0] wb_pb [BF_LAT];
    logic              out_vld;

    assign load_acc   = (state == S_LOAD) && bus.i_in_valid;
    assign last_cnt   = &cnt;
    assign last_bf    = &bf_k;
    assign last_stage = (stage == SW'(STAGES - 1));
    assign last_drain = (drain_cnt == DW'(BF_LAT - 1));
    assign rd_en      = (state == S_COMPUTE);

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:    if (bus.i_start) state_nxt = S_LOAD;
            S_LOAD:    if (load_acc && last_cnt) state_nxt = S_COMPUTE;
            S_COMPUTE: if (last_bf) state_nxt = S_DRAIN;
            S_DRAIN:   if (last_drain) state_nxt = last_stage ? S_UNLOAD : S_COMPUTE;
            S_UNLOAD:  if (last_cnt) state_nxt = S_DONE;
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // cnt serves both load and unload; it wraps to zero after N so no explicit clear is needed
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bf_k      <= '0;
            stage     <= '0;
            drain_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (load_acc || (state == S_UNLOAD)) cnt <= cnt + STAGES'(1);
            if (state == S_COMPUTE) bf_k <= bf_k + KW'(1);
            if (state == S_DRAIN) drain_cnt <= last_drain ? '0 : drain_cnt + DW'(1);
            if ((state == S_DRAIN) && last_drain && !last_stage) stage <= stage + SW'(1);
            if (state == S_DONE) stage <= '0;
        end
    end

    always_comb begin
        load_rev = '0;
        for (int i = 0; i < STAGES; i++) load_rev[i] = cnt[STAGES-1-i];
    end

    // Insert a zero at bit position 'stage' of k to get the upper operand of the pair
    assign tw_shift = SW'(STAGES - 1) - stage;
    always_comb begin
        k_ext   = {1'b0, bf_k};
        lo_mask = (STAGES'(1) << stage) - STAGES'(1);
        lo_bits = k_ext & lo_mask;
        addr_a  = ((k_ext & ~lo_mask) << 1) | lo_bits;
        addr_b  = addr_a | (STAGES'(1) << stage);
        tw_full = lo_bits << tw_shift;
    end

    assign rd_a = rd_en ? addr_a : '0;
    assign rd_b = rd_en ? addr_b : '0;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wb_vld  <= '0;
            out_vld <= 1'b0;
            for (int i = 0; i < BF_LAT; i++) begin
                wb_pa[i] <= '0;
                wb_pb[i] <= '0;
            end
        end else begin
            out_vld   <= (state == S_UNLOAD);
            wb_vld[0] <= rd_en;
            wb_pa[0]  <= rd_a;
            wb_pb[0]  <= rd_b;
            for (int i = 1; i < BF_LAT; i++) begin
                wb_vld[i] <= wb_vld[i-1];
                wb_pa[i]  <= wb_pa[i-1];
                wb_pb[i]  <= wb_pb[i-1];
            end
        end
    end

    assign bus.o_in_ready  = (state == S_LOAD);
    assign bus.o_load_we   = load_acc;
    assign bus.o_load_addr = load_acc ? load_rev : '0;
    assign bus.o_rd_en     = rd_en;
    assign bus.o_rd_addr_a = rd_a;
    assign bus.o_rd_addr_b = rd_b;
    assign bus.o_tw_idx    = rd_en ? tw_full[KW-1:0] : '0;
    assign bus.o_wb_en     = wb_vld[BF_LAT-1];
    assign bus.o_wb_addr_a = wb_pa[BF_LAT-1];
    assign bus.o_wb_addr_b = wb_pb[BF_LAT-1];
    assign bus.o_out_rd_en = (state == S_UNLOAD);
    assign bus.o_out_addr  = (state == S_UNLOAD) ? cnt : '0;
    assign bus.o_out_valid = out_vld;
    assign bus.o_stage     = stage;
    assign bus.o_busy      = (state != S_IDLE);
    assign bus.o_done      = (state == S_DONE);
endmodule
